spi_transmit_quad: RTL and testbench



---
 rtl/spi_transmit_quad.sv | 206 ++++++++++++++++++++
 tb/tb_spi_transmit_quad.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transmit_quad.sv
// Quad-line SPI transmitter: FIFO-fed, generates DCLK/CS, MSB beat first.
// Optional SPI_TX_LAST_EN adds data_last_in to close a burst after a tagged word.
module spi_transmit_quad #(
  parameter int DATA_WIDTH      = 8,
  parameter int LINES           = 4,
  parameter int DATA_CLK_PERIOD = 6,
  parameter int FIFO_DEPTH      = 4,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_IDLE_CYCLES  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
`ifdef SPI_TX_LAST_EN
  input  logic                  data_last_in,
`endif
  output logic                  data_ready_out,
  output logic                  busy_out,
  output logic [LINES-1:0]      chip_data_out,
  output logic                  chip_clk_out,
  output logic                  chip_sel_out
);

  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int LOW   = DATA_CLK_PERIOD / 2;
  localparam int HIGH  = DATA_CLK_PERIOD - LOW;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = 16;
`ifdef SPI_TX_LAST_EN
  localparam int EW    = DATA_WIDTH + 1;
`else
  localparam int EW    = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOW_PH,
    HIGH_PH,
    HOLD
  } state_t;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nx;
  logic [EW-1:0]         entry_in;
  logic [EW-1:0]         head;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  push;
  logic                  pop;
  logic                  empty;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         beat;
  logic [CW-1:0]         idle_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nx;
  logic                  cur_last;
  logic                  idle_done;
  logic                  lo_done;
  logic                  hi_done;
  logic                  hold_done;
  logic                  last_beat;
  logic                  cs_nx;

`ifdef SPI_TX_LAST_EN
  assign entry_in  = {data_last_in, data_in};
  assign head_last = head[EW-1];
`else
  assign entry_in  = data_in;
  assign head_last = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign head_data = head[DATA_WIDTH-1:0];
  assign push      = data_valid_in && data_ready_out;
  assign empty     = (count == '0);

  assign idle_done = (idle_cnt == CW'(CS_IDLE_CYCLES - 1));
  assign lo_done   = (cnt == CW'(LOW - 1));
  assign hi_done   = (cnt == CW'(HIGH - 1));
  assign hold_done = (cnt == CW'(CS_HOLD_CYCLES - 1));
  assign last_beat = (beat == CW'(BEATS - 1));
  assign sh_nx     = sh << LINES;

  // A word is chained onto the burst only at the last beat of the previous one.
  assign pop = (state == IDLE && !empty && idle_done)
            || (state == HIGH_PH && hi_done && last_beat
                && !empty && !cur_last);

  always_comb begin
    cs_nx = chip_sel_out;
    if (pop)
      cs_nx = 1'b0;
    else if (state == HOLD && hold_done)
      cs_nx = 1'b1;
  end

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + (AW+1)'(1);
    else if (pop && !push)
      count_nx = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_in) begin
    if (push)
      mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_ready_out <= 1'b1;
      busy_out       <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count          <= count_nx;
      data_ready_out <= (count_nx != (AW+1)'(FIFO_DEPTH));
      busy_out       <= !cs_nx || (count_nx != '0);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      beat          <= '0;
      idle_cnt      <= CW'(CS_IDLE_CYCLES - 1);
      sh            <= '0;
      cur_last      <= 1'b0;
      chip_sel_out  <= 1'b1;
      chip_clk_out  <= 1'b0;
      chip_data_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!idle_done)
            idle_cnt <= idle_cnt + CW'(1);
          if (pop) begin
            sh            <= head_data;
            chip_data_out <= head_data[DATA_WIDTH-1 -: LINES];
            cur_last      <= head_last;
            chip_sel_out  <= 1'b0;
            cnt           <= '0;
            beat          <= '0;
            state         <= LOW_PH;
          end
        end
        LOW_PH: begin
          if (lo_done) begin
            chip_clk_out <= 1'b1;
            cnt          <= '0;
            state        <= HIGH_PH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH_PH: begin
          if (hi_done) begin
            chip_clk_out <= 1'b0;
            cnt          <= '0;
            if (!last_beat) begin
              beat          <= beat + CW'(1);
              sh            <= sh_nx;
              chip_data_out <= sh_nx[DATA_WIDTH-1 -: LINES];
              state         <= LOW_PH;
            end else if (pop) begin
              sh            <= head_data;
              chip_data_out <= head_data[DATA_WIDTH-1 -: LINES];
              cur_last      <= head_last;
              beat          <= '0;
              state         <= LOW_PH;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (hold_done) begin
            chip_sel_out  <= 1'b1;
            chip_data_out <= '0;
            idle_cnt      <= '0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transmit_quad.sv
// Scoreboard bench for spi_transmit_quad: pushes expected beats/bursts,
// a negedge monitor checks every DCLK rise, CS edge and phase timing.
module tb_spi_transmit_quad;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid_in = 1'b0;
`ifdef SPI_TX_LAST_EN
  logic       data_last_in = 1'b0;
`endif
  logic       data_ready_out;
  logic       busy_out;
  logic [3:0] chip_data_out;
  logic       chip_clk_out;
  logic       chip_sel_out;

  spi_transmit_quad dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
`ifdef SPI_TX_LAST_EN
    .data_last_in   (data_last_in),
`endif
    .data_ready_out (data_ready_out),
    .busy_out       (busy_out),
    .chip_data_out  (chip_data_out),
    .chip_clk_out   (chip_clk_out),
    .chip_sel_out   (chip_sel_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  int burst_q[$];
  int total_rises = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: DCLK/CS edge timing and beat data against the scoreboard.
  initial begin
    logic       prev_cs;
    logic       prev_clk;
    logic [3:0] rise_data;
    int         rises;
    int         t_csfall;
    int         t_rise;
    int         t_fall;
    int         t_csrise;
    bit         have_csrise;
    prev_cs = 1'b1; prev_clk = 1'b0; rise_data = '0;
    rises = 0; t_csfall = 0; t_rise = 0; t_fall = 0;
    t_csrise = 0; have_csrise = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_cs = 1'b1;
        prev_clk = 1'b0;
        rises = 0;
        have_csrise = 0;
      end else begin
        if (prev_cs && !chip_sel_out) begin
          if (have_csrise)
            chk("cs idle gap>=2", 32'(cyc - t_csrise >= 2), 1);
          t_csfall = cyc;
          rises = 0;
        end
        if (prev_clk && chip_clk_out)
          chk("data stable high", chip_data_out, rise_data);
        if (!prev_clk && chip_clk_out) begin
          if (rises == 0)
            chk("cs to rise1", cyc - t_csfall, 3);
          else
            chk("rise period", cyc - t_rise, 6);
          chk("cs low at rise", chip_sel_out, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected beat: got %0h expected none",
                     chip_data_out);
          end else begin
            chk("beat data", chip_data_out, exp_q.pop_front());
          end
          rise_data = chip_data_out;
          t_rise = cyc;
          rises++;
          total_rises++;
        end
        if (prev_clk && !chip_clk_out)
          t_fall = cyc;
        if (!prev_cs && chip_sel_out) begin
          chk("cs hold", cyc - t_fall, 2);
          if (burst_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected burst: got %0d rises expected none",
                     rises);
          end else begin
            chk("burst rises", rises, burst_q.pop_front());
          end
          t_csrise = cyc;
          have_csrise = 1;
        end
        prev_cs = chip_sel_out;
        prev_clk = chip_clk_out;
      end
    end
  end

  task automatic push_word(input logic [7:0] w, input logic last);
    int n;
    n = 0;
    data_in = w;
    data_valid_in = 1'b1;
`ifdef SPI_TX_LAST_EN
    data_last_in = last;
`else
    if (last) $display("note: last tag ignored in this build");
`endif
    while (!data_ready_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("push timeout", 32'(n < 200), 1);
    @(posedge clk_in);
    exp_q.push_back(w[7:4]);
    exp_q.push_back(w[3:0]);
    @(negedge clk_in);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_out && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("idle timeout", 32'(n < 1000), 1);
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    int base;
    int n;
    #1 rst_in = 1'b1;
    #2;
    chk("rst cs", chip_sel_out, 1);
    chk("rst dclk", chip_clk_out, 0);
    chk("rst data", chip_data_out, 0);
    chk("rst busy", busy_out, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("ready after rst", data_ready_out, 1);

    // single word
    burst_q.push_back(2);
    base = total_rises;
    push_word(8'hA5, 1'b0);
    data_valid_in = 1'b0;
    chk("busy after push", busy_out, 1);
    wait_idle();
    chk("single rises", total_rises - base, 2);
    chk("idle cs", chip_sel_out, 1);

    // back-to-back words in one burst
    burst_q.push_back(6);
    base = total_rises;
    push_word(8'h12, 1'b0);
    push_word(8'h34, 1'b0);
    push_word(8'h56, 1'b0);
    data_valid_in = 1'b0;
    wait_idle();
    chk("b2b rises", total_rises - base, 6);

    // backpressure
    burst_q.push_back(12);
    base = total_rises;
    push_word(8'h01, 1'b0);
    push_word(8'h23, 1'b0);
    push_word(8'h45, 1'b0);
    push_word(8'h67, 1'b0);
    chk("ready with 3 queued", data_ready_out, 1);
    push_word(8'h89, 1'b0);
    chk("ready with 4 queued", data_ready_out, 0);
    push_word(8'hAB, 1'b0);
    data_valid_in = 1'b0;
    wait_idle();
    chk("bp rises", total_rises - base, 12);

    // reset during high phase of beat 0
    burst_q.push_back(2);
    push_word(8'hF0, 1'b0);
    data_valid_in = 1'b0;
    n = 0;
    while (!chip_clk_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("reach high phase", 32'(n < 50), 1);
    #1 rst_in = 1'b1;
    exp_q.delete();
    burst_q.delete();
    #1;
    chk("midrst cs", chip_sel_out, 1);
    chk("midrst dclk", chip_clk_out, 0);
    chk("midrst data", chip_data_out, 0);
    chk("midrst busy", busy_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    base = total_rises;
    repeat (30) @(negedge clk_in);
    chk("no tx after rst", total_rises - base, 0);
    chk("cs high after rst", chip_sel_out, 1);
    chk("fifo flushed", busy_out, 0);
    chk("ready after midrst", data_ready_out, 1);

    // second word arrives during HOLD
    burst_q.push_back(2);
    burst_q.push_back(2);
    base = total_rises;
    push_word(8'hC3, 1'b0);
    data_valid_in = 1'b0;
    n = 0;
    while (!(total_rises == base + 2 && !chip_clk_out) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("reach hold", 32'(n < 100), 1);
    push_word(8'h3C, 1'b0);
    data_valid_in = 1'b0;
    wait_idle();
    chk("gap rises", total_rises - base, 4);

`ifdef SPI_TX_LAST_EN
    burst_q.push_back(2);
    burst_q.push_back(2);
    base = total_rises;
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b0);
    data_valid_in = 1'b0;
    data_last_in = 1'b0;
    wait_idle();
    chk("last rises", total_rises - base, 4);
`endif

    chk("beats left", exp_q.size(), 0);
    chk("bursts left", burst_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
